uart_rx: RTL and testbench

Frame receiver paired with `uart_tx` on the serial link. Samples the serial line once per bit-clock cycle, reconstructs 5–8-bit frames (start, data LSB-first, optional parity, one or two stops), and presents the parallel word with parity/framing status. Runs on the same bit clock as the transmitter, so a direct `tx -> rx` loopback is a legal configuration.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: bit-clock serial frame receiver.
// Start, 5-8 data bits LSB first, optional parity, one or two stops.
module uart_rx (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] length,
  input  logic       parity_type,
  input  logic       parity_en,
  input  logic       stop2,
  output logic [7:0] rx_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  last_q, last_d;
  logic [7:0]  shift_q, shift_d;
  logic        ptype_q, ptype_d;
  logic        pen_q, pen_d;
  logic        s2_q, s2_d;
  logic        pacc_q, pacc_d;
  logic        facc_q, facc_d;
  logic [7:0]  out_q, out_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        done_q, done_d;
  logic        len_ok;

  assign len_ok = (length >= 4'd5) && (length <= 4'd8);

  // State register.
  always_ff @(posedge rx_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: walk start, data, parity, stops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rx) state_d = S_DATA;
      S_DATA: begin
        if (cnt_q == last_q)
          state_d = pen_q ? S_PAR : S_STOP1;
      end
      S_PAR:   state_d = S_STOP1;
      S_STOP1: state_d = s2_q ? S_STOP2 : S_IDLE;
      S_STOP2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: sample bits, check parity and stops.
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    shift_d = shift_q;
    ptype_d = ptype_q;
    pen_d   = pen_q;
    s2_d    = s2_q;
    pacc_d  = pacc_q;
    facc_d  = facc_q;
    out_d   = out_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          cnt_d   = 3'd0;
          last_d  = len_ok ? (length[2:0] - 3'd1) : 3'd7;
          shift_d = 8'd0;
          ptype_d = parity_type;
          pen_d   = parity_en;
          s2_d    = stop2;
          pacc_d  = 1'b0;
          facc_d  = 1'b0;
        end
      end
      S_DATA: begin
        shift_d[cnt_q] = rx;
        cnt_d = cnt_q + 3'd1;
      end
      S_PAR: begin
        pacc_d = rx ^ (ptype_q ? ^shift_q : ~^shift_q);
      end
      S_STOP1: begin
        facc_d = ~rx;
        if (!s2_q) begin
          out_d  = shift_q;
          perr_d = pacc_q;
          ferr_d = ~rx;
          done_d = 1'b1;
        end
      end
      S_STOP2: begin
        out_d  = shift_q;
        perr_d = pacc_q;
        ferr_d = facc_q | ~rx;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      last_q  <= 3'd7;
      shift_q <= 8'd0;
      ptype_q <= 1'b0;
      pen_q   <= 1'b0;
      s2_q    <= 1'b0;
      pacc_q  <= 1'b0;
      facc_q  <= 1'b0;
      out_q   <= 8'd0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      ptype_q <= ptype_d;
      pen_q   <= pen_d;
      s2_q    <= s2_d;
      pacc_q  <= pacc_d;
      facc_q  <= facc_d;
      out_q   <= out_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  assign rx_out     = out_q;
  assign rx_done    = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of uart_rx.
// Directed frames plus randomized frames, checked every cycle.
module tb_uart_rx;

  localparam int MAXE = 8192;

  logic       rx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] length = 4'd8;
  logic       parity_type = 1'b0;
  logic       parity_en = 1'b0;
  logic       stop2 = 1'b0;
  logic [7:0] rx_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  uart_rx dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx          (rx),
    .length      (length),
    .parity_type (parity_type),
    .parity_en   (parity_en),
    .stop2       (stop2),
    .rx_out      (rx_out),
    .rx_done     (rx_done),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 rx_clk = ~rx_clk;

  int ecnt = 0;
  always @(posedge rx_clk) ecnt <= ecnt + 1;

  int errors = 0;
  int checks = 0;

  bit         exp_busy [MAXE];
  bit         exp_done [MAXE];
  bit         exp_rst  [MAXE];
  logic [7:0] exp_word [MAXE];
  bit         exp_pe   [MAXE];
  bit         exp_fe   [MAXE];

  logic [7:0] cur_word = 8'd0;
  logic       cur_pe = 1'b0;
  logic       cur_fe = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, ecnt, act, want);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  always @(negedge rx_clk) begin
    int k;
    if (ecnt > 0 && ecnt <= MAXE) begin
      k = ecnt - 1;
      if (exp_rst[k]) begin
        cur_word = 8'd0;
        cur_pe   = 1'b0;
        cur_fe   = 1'b0;
      end
      if (exp_done[k]) begin
        cur_word = exp_word[k];
        cur_pe   = exp_pe[k];
        cur_fe   = exp_fe[k];
      end
      chk("rx_done", {7'd0, rx_done}, {7'd0, exp_done[k]});
      chk("rx_busy", {7'd0, rx_busy}, {7'd0, exp_busy[k]});
      chk("rx_out", rx_out, cur_word);
      chk("parity_err", {7'd0, parity_err}, {7'd0, cur_pe});
      chk("frame_err", {7'd0, frame_err}, {7'd0, cur_fe});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge rx_clk);
      rst = 1'b0;
      rx  = 1'b1;
      length      = 4'($urandom_range(0, 15));
      parity_type = 1'($urandom);
      parity_en   = 1'($urandom);
      stop2       = 1'($urandom);
      @(posedge rx_clk);
    end
  endtask

  // One idle-high cycle, then look at the outputs.
  task automatic peek;
    @(negedge rx_clk);
    rst = 1'b0;
    rx  = 1'b1;
  endtask

  task automatic send_frame(input int len, input bit pt, input bit pe,
                            input bit s2, input logic [7:0] d,
                            input bit bp, input bit bs1, input bit bs2,
                            input int abort_in, input int tw);
    int L, nb, s, k, ab;
    logic [15:0] mk;
    logic [7:0] m;
    bit par;
    bit b[$];
    L  = (len >= 5 && len <= 8) ? len : 8;
    mk = (16'd1 << L) - 16'd1;
    m  = d & mk[7:0];
    par = pt ? ^m : ~^m;
    b.push_back(1'b0);
    for (int i = 0; i < L; i++) b.push_back(m[i]);
    if (pe) b.push_back(par ^ bp);
    b.push_back(~bs1);
    if (s2) b.push_back(~bs2);
    nb = b.size();
    ab = (abort_in >= nb) ? nb - 1 : abort_in;
    s  = 0;
    for (int i = 0; i < nb; i++) begin
      @(negedge rx_clk);
      k = ecnt;
      rst = (ab > 0 && i == ab);
      if (i == 0) begin
        s = k;
        length      = 4'(len);
        parity_type = pt;
        parity_en   = pe;
        stop2       = s2;
        if (ab == 0) begin
          for (int j = 0; j < nb - 1; j++) exp_busy[s + j] = 1'b1;
          exp_done[s + nb - 1] = 1'b1;
          exp_word[s + nb - 1] = m;
          exp_pe[s + nb - 1]   = pe & bp;
          exp_fe[s + nb - 1]   = bs1 | (s2 & bs2);
        end else begin
          for (int j = 0; j < ab; j++) exp_busy[s + j] = 1'b1;
        end
      end else if (tw == 1) begin
        length      = 4'($urandom_range(0, 15));
        parity_type = 1'($urandom);
        parity_en   = 1'($urandom);
        stop2       = 1'($urandom);
      end else if (tw == 2 && i == 2) begin
        length = 4'd5;
      end
      if (rst) exp_rst[k] = 1'b1;
      rx = b[i];
      @(posedge rx_clk);
      if (ab > 0 && i == ab) break;
    end
  endtask

  initial begin
    logic [7:0] lw [3];
    lw[0] = 8'h55;
    lw[1] = 8'h2A;
    lw[2] = 8'h7F;

    repeat (3) begin
      @(negedge rx_clk);
      rst = 1'b1;
      rx  = 1'b1;
      exp_rst[ecnt] = 1'b1;
      @(posedge rx_clk);
    end
    idle(2);
    peek;
    chk("reset_out", rx_out, 8'h00);
    chk("reset_busy", {7'd0, rx_busy}, 8'h00);

    send_frame(8, 1, 1, 0, 8'hA5, 0, 0, 0, 0, 0);
    peek;
    chk("t1_done", {7'd0, rx_done}, 8'h01);
    chk("t1_out", rx_out, 8'hA5);
    chk("t1_pe", {7'd0, parity_err}, 8'h00);
    chk("t1_fe", {7'd0, frame_err}, 8'h00);

    send_frame(8, 1, 1, 0, 8'hA5, 1, 0, 0, 0, 0);
    peek;
    chk("t2_out", rx_out, 8'hA5);
    chk("t2_pe", {7'd0, parity_err}, 8'h01);
    chk("t2_fe", {7'd0, frame_err}, 8'h00);

    send_frame(5, 0, 0, 1, 8'h1B, 0, 0, 1, 0, 0);
    peek;
    chk("t3_done", {7'd0, rx_done}, 8'h01);
    chk("t3_out", rx_out, 8'h1B);
    chk("t3_fe", {7'd0, frame_err}, 8'h01);

    send_frame(8, 1, 0, 0, 8'hFF, 0, 0, 0, 4, 0);
    peek;
    chk("rst_out", rx_out, 8'h00);
    chk("rst_busy", {7'd0, rx_busy}, 8'h00);
    chk("rst_done", {7'd0, rx_done}, 8'h00);
    chk("rst_fe", {7'd0, frame_err}, 8'h00);
    idle(3);
    send_frame(8, 0, 0, 0, 8'h3C, 0, 0, 0, 0, 0);
    peek;
    chk("t4_out", rx_out, 8'h3C);

    send_frame(8, 1, 0, 0, 8'hC3, 0, 0, 0, 0, 2);
    peek;
    chk("t5_out", rx_out, 8'hC3);

    for (int i = 0; i < 3; i++) begin
      send_frame(7, 0, 1, 1, lw[i], 0, 0, 0, 0, 0);
      peek;
      chk("lb_done", {7'd0, rx_done}, 8'h01);
      chk("lb_out", rx_out, lw[i]);
      chk("lb_pe", {7'd0, parity_err}, 8'h00);
      chk("lb_fe", {7'd0, frame_err}, 8'h00);
    end

    send_frame(6, 1, 1, 0, 8'h2D, 0, 0, 0, 0, 0);
    send_frame(8, 0, 0, 1, 8'h96, 0, 0, 0, 0, 0);
    idle(2);

    for (int n = 0; n < 150; n++) begin
      int ab;
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 10) : 0;
      send_frame($urandom_range(0, 15), 1'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, ab, $urandom_range(0, 1));
      idle($urandom_range(0, 3));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
